spram_burst_mst: RTL

Burst initiator that drives the single-port byte-write RAM port (en/addr/din/we, 1-cycle registered dout). It accepts one read or write burst command at a time. Write data is streamed in over a valid/ready channel. Read data is streamed out over a valid/ready channel with full backpressure and no lost beats. It sits between DMA/host logic and the RAM macro and is the only RAM port master.

---
 rtl/spram_pkg.sv | 19 +
 rtl/spram_burst_mst_if.sv | 41 ++++
 rtl/spram_rd_fifo2.sv | 47 ++++
 rtl/spram_burst_mst.sv | 102 ++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared types and constants for the single-port RAM burst master and its RAM.
package spram_pkg;
  localparam int RAM_DW = 32;
  localparam int BE_W   = 4;
  localparam int AW_DEF = 12;
  localparam int LW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_CPL  = 2'd3
  } state_e;

  typedef struct packed {
    logic              last;
    logic [RAM_DW-1:0] data;
  } rbeat_t;
endpackage

// File: rtl/spram_burst_mst_if.sv
// Command, write-stream, read-stream and RAM-port signals of the burst master.
interface spram_burst_mst_if
  import spram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AW-1:0]     cmd_addr;
  logic [LW-1:0]     cmd_len;
  logic [BE_W-1:0]   cmd_be;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [RAM_DW-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [RAM_DW-1:0] rdata;
  logic              rdata_last;
  logic              done;
  logic              ram_en;
  logic [AW-1:0]     ram_addr;
  logic [RAM_DW-1:0] ram_din;
  logic [BE_W-1:0]   ram_we;
  logic [RAM_DW-1:0] ram_dout;

  modport mst (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
    input  wdata_valid, wdata, rdata_ready, ram_dout,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
    output ram_en, ram_addr, ram_din, ram_we
  );

  modport slv (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be,
    output wdata_valid, wdata, rdata_ready, ram_dout,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
    input  ram_en, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/spram_rd_fifo2.sv
// Two-entry FIFO holding returned read beats tagged with their last flag.
module spram_rd_fifo2
  import spram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       i_push,
  input  logic       i_pop,
  input  rbeat_t     i_din,
  output rbeat_t     o_dout,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);
  rbeat_t     r_mem [2];
  logic       r_wp, r_rp;
  logic [1:0] r_count;
  logic       w_push_ok, w_pop_ok;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rp];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop_ok) r_rp <= ~r_rp;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spram_burst_mst.sv
// Burst master for a single-port byte-write RAM: streamed write bursts and
// credit-limited read bursts returned through a 2-entry buffer with bypass.
module spram_burst_mst
  import spram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic            clk,
  input  logic            rst_b,
  spram_burst_mst_if.mst  bus
);
  state_e          r_state;
  logic [AW-1:0]   r_cur;
  logic [LW-1:0]   r_left;
  logic [BE_W-1:0] r_be;
  logic            r_iss_done;
  logic            r_inflight;
  logic            r_if_last;

  logic            w_wdata_ready, w_wr_hs;
  logic            w_issue, w_rvalid, w_pop, w_push, w_fifo_pop;
  logic            w_fifo_full, w_fifo_empty;
  logic [1:0]      w_count;
  rbeat_t          w_fifo_dout, w_head, w_ret;

  assign w_wdata_ready = rst_b && (r_state == ST_WR);
  assign w_wr_hs       = bus.wdata_valid && w_wdata_ready;

  // Credit of two covers the buffer plus the one read whose data is still in the RAM.
  assign w_issue = rst_b && (r_state == ST_RD) && !r_iss_done &&
                   ((w_count + 2'(r_inflight)) < 2'd2);

  assign w_ret      = '{last: r_if_last, data: bus.ram_dout};
  assign w_head     = w_fifo_empty ? w_ret : w_fifo_dout;
  assign w_rvalid   = rst_b && (r_state == ST_RD) && (!w_fifo_empty || r_inflight);
  assign w_pop      = w_rvalid && bus.rdata_ready;
  // Returning beat bypasses the buffer when it is consumed on arrival.
  assign w_push     = r_inflight && !(w_pop && w_fifo_empty) && !w_fifo_full;
  assign w_fifo_pop = w_pop && !w_fifo_empty;

  spram_rd_fifo2 u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_push),
    .i_pop   (w_fifo_pop),
    .i_din   (w_ret),
    .o_dout  (w_fifo_dout),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.cmd_ready   = rst_b && (r_state == ST_IDLE);
  assign bus.done        = rst_b && (r_state == ST_CPL);
  assign bus.wdata_ready = w_wdata_ready;
  assign bus.rdata_valid = w_rvalid;
  assign bus.rdata       = w_rvalid ? w_head.data : '0;
  assign bus.rdata_last  = w_rvalid && w_head.last;
  assign bus.ram_en      = w_wr_hs || w_issue;
  assign bus.ram_we      = w_wr_hs ? r_be : '0;
  assign bus.ram_addr    = bus.ram_en ? r_cur : '0;
  assign bus.ram_din     = w_wr_hs ? bus.wdata : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_left     <= '0;
      r_be       <= '0;
      r_iss_done <= 1'b0;
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: if (bus.cmd_valid) begin
          r_cur      <= bus.cmd_addr;
          r_left     <= bus.cmd_len;
          r_be       <= bus.cmd_be;
          r_iss_done <= 1'b0;
          r_state    <= bus.cmd_write ? ST_WR : ST_RD;
        end
        ST_WR: if (w_wr_hs) begin
          r_cur  <= r_cur + AW'(1);
          r_left <= r_left - LW'(1);
          if (r_left == '0) r_state <= ST_CPL;
        end
        ST_RD: begin
          if (w_issue) begin
            r_cur     <= r_cur + AW'(1);
            r_left    <= r_left - LW'(1);
            r_if_last <= (r_left == '0);
            if (r_left == '0) r_iss_done <= 1'b1;
          end
          if (w_pop && w_head.last) r_state <= ST_CPL;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
